// File: rtl/reorder_pkg.sv
// -----------------------------------------------------------------------------
// reorder_pkg
// Shared types for the reorder result streamer.
//   IDX_W           width of an image index / image count
//   CHK_W           width of the optional output checksum
//   stream_state_t  streamer FSM states
//   result_entry_t  one FIFO entry: output sequence position + image index
// -----------------------------------------------------------------------------
package reorder_pkg;

   localparam int IDX_W = 9;
   localparam int CHK_W = 16;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DRAIN   = 2'd2,
      S_DONE    = 2'd3
   } stream_state_t;

   typedef struct packed {
      logic [IDX_W-1:0] seq;
      logic [IDX_W-1:0] idx;
   } result_entry_t;

   // States in which the reorder engine may hand us new indices.
   function automatic logic accepts_push(input stream_state_t s);
      return (s == S_COLLECT) || (s == S_DRAIN);
   endfunction

endpackage

// File: rtl/result_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
// Synchronous FIFO of result_entry_t. The head entry is read straight out of
// the storage registers, so a pushed entry becomes visible one cycle after the
// push (no same-cycle fall-through).
// Ports:
//   clk, reset   clock, asynchronous active-low reset (pointers only)
//   push         write wr_data; honoured when not full, or full with a pop
//   pop          drop the head entry; ignored when empty
//   wr_data      entry to write
//   rd_data      head entry (meaningful only when !empty)
//   full, empty  occupancy flags
// -----------------------------------------------------------------------------
module result_fifo
   import reorder_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  result_entry_t wr_data,
   output result_entry_t rd_data,
   output logic          full,
   output logic          empty
);

   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit distinguishes full from empty; wrap is normal.
   typedef logic [AW:0] ptr_t;

   result_entry_t mem [DEPTH];
   ptr_t          wr_ptr;
   ptr_t          rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // When full, the slot being written is the one being popped this cycle.
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
         if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/reorder_result_streamer.sv
// -----------------------------------------------------------------------------
// reorder_result_streamer
// Captures reference indices produced by the reorder engine into a FIFO and
// streams them to the host tagged with their output position, flagging the
// last expected entry.
//
// Optional feature: define STREAM_CHECKSUM_EN to build a 16-bit running sum of
// accepted out_index values; otherwise checksum is tied to zero.
//
// Ports:
//   clk                    system clock
//   reset                  asynchronous active-low reset
//   start                  1-cycle pulse, arms a stream (ignored unless idle)
//   num_images             expected entry count, sampled on start
//   new_reference_is_done  1-cycle pulse qualifying temp_new_reference
//   temp_new_reference     image index chosen by the reorder engine
//   finish_reordering      engine has finished producing
//   out_valid/out_ready    host stream handshake
//   out_index, out_seq     reordered index and its 0-based position
//   out_last               entry is position num_images-1
//   busy                   streamer not idle
//   stream_done            1-cycle pulse once the stream has fully drained
//   err                    sticky: overflow, excess entries or short stream
//   checksum               running sum of accepted indices (see above)
//   dbg_state              current FSM state
// -----------------------------------------------------------------------------
module reorder_result_streamer
   import reorder_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [IDX_W-1:0] num_images,
   input  logic             new_reference_is_done,
   input  logic [IDX_W-1:0] temp_new_reference,
   input  logic             finish_reordering,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_index,
   output logic [IDX_W-1:0] out_seq,
   output logic             out_last,
   output logic             busy,
   output logic             stream_done,
   output logic             err,
   output logic [CHK_W-1:0] checksum,
   output stream_state_t    dbg_state
);

   stream_state_t    state;
   stream_state_t    state_nxt;
   logic [IDX_W-1:0] num_lat;
   logic [IDX_W-1:0] wr_cnt;
   logic [IDX_W-1:0] wr_cnt_nxt;
   logic             err_q;

   logic             push_win;
   logic             room;
   logic             push;
   logic             pop;
   logic             push_err;
   logic             short_err;
   logic             start_ok;

   result_entry_t    push_entry;
   result_entry_t    fifo_head;
   logic             fifo_full;
   logic             fifo_empty;

   // Handshake: out_valid rises when the FIFO holds an entry and stays high
   // until the host takes it (out_valid & out_ready); the payload is the FIFO
   // head and cannot change while it waits. Each acceptance pops exactly one
   // entry and the next one, if present, is offered in the following cycle.
   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;

   assign start_ok  = (state == S_IDLE) && start;
   assign push_win  = accepts_push(state) && new_reference_is_done;
   // wr_cnt saturates at num_lat, so the sequence tag never wraps.
   assign room      = (wr_cnt < num_lat);
   assign push      = push_win && room && (!fifo_full || pop);
   assign push_err  = push_win && !push;
   assign wr_cnt_nxt = wr_cnt + IDX_W'(push);
   // Engine finished before delivering num_images entries.
   assign short_err = (state == S_COLLECT) && finish_reordering &&
                      (wr_cnt_nxt < num_lat);

   assign push_entry.seq = wr_cnt;
   assign push_entry.idx = temp_new_reference;

   result_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .pop     (pop),
      .wr_data (push_entry),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = (num_images == '0) ? S_DONE : S_COLLECT;
         end
         S_COLLECT: begin
            if (finish_reordering) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (fifo_empty && !push) state_nxt = S_DONE;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         num_lat <= '0;
         wr_cnt  <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (start_ok) begin
            num_lat <= num_images;
            wr_cnt  <= '0;
            err_q   <= 1'b0;
         end else begin
            wr_cnt <= wr_cnt_nxt;
            if (push_err || short_err) err_q <= 1'b1;
         end
      end
   end

   // Payload is forced to zero while nothing is offered.
   assign out_index   = out_valid ? fifo_head.idx : '0;
   assign out_seq     = out_valid ? fifo_head.seq : '0;
   assign out_last    = out_valid && (fifo_head.seq == (num_lat - IDX_W'(1)));
   assign busy        = (state != S_IDLE);
   assign stream_done = (state == S_DONE);
   assign err         = err_q;
   assign dbg_state   = state;

`ifdef STREAM_CHECKSUM_EN
   logic [CHK_W-1:0] chk_q;

   // No pops happen after DONE, so the sum holds until the next start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         chk_q <= '0;
      end else if (start_ok) begin
         chk_q <= '0;
      end else if (pop) begin
         chk_q <= chk_q + {{(CHK_W-IDX_W){1'b0}}, fifo_head.idx};
      end
   end

   assign checksum = chk_q;
`else
   assign checksum = '0;
`endif

endmodule
